mux_nx1_reg: RTL
================

Name: mux_nx1_reg

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Two selection modes:
  - fixed select: the sel port picks the channel.
  - round-robin: an internal pointer rotates among the valid channels.
- Successor to the combinational 2:1 enable mux. Used wherever several producers share one downstream consumer.

Parameters:
- WIDTH, 16, data width per channel in bits (≥1)
- N, 4, number of input channels (≥2)
- SELW, $clog2(N), width of sel and out_chan (derived; not overridden)

Ports:
- clk        input   1         rising-edge clock
- rst        input   1         synchronous reset, active-high
- enable     input   1         1 = new grants allowed; 0 = no input accepted
- mode       input   1         0 = fixed select via sel; 1 = round-robin
- sel        input   SELW      channel index used when mode=0
- in_data    input   N*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid   input   N         per-channel valid
- in_ready   output  N         per-channel ready, at most one bit set (combinational)
- out_data   output  WIDTH     registered output data
- out_valid  output  1         registered output valid
- out_ready  input   1         downstream ready
- out_chan   output  SELW      index of the channel that produced out_data

Behaviour:

Reset:
- When rst=1 at a clk edge: out_data=0, out_valid=0, out_chan=0, rr_ptr=N-1.
- rr_ptr=N-1 means channel 0 has first round-robin priority.
- rst overrides every other input, including a transfer in progress. Any held word is dropped.
- in_ready is forced to 0 while rst=1.

Load condition:
- load = enable && (!out_valid || out_ready).
- The output register accepts a new word only when load=1. This allows back-to-back throughput of one word per cycle.

Grant (combinational, evaluated only when load=1):
- mode=0: grant = sel if sel<N and in_valid[sel]=1; otherwise no grant.
  - sel≥N (N not a power of 2) gives no grant and is not an error.
- mode=1: scan channels rr_ptr+1, rr_ptr+2, … modulo N. Grant the first channel with in_valid=1. If none are valid, no grant.
- in_ready[g]=1 only for the granted channel g. All other bits are 0.
- If there is no grant, in_ready is all zeros.

Transfer in (in_valid[g] && in_ready[g] at a clk edge):
- out_data <= in_data[g]
- out_chan <= g
- out_valid <= 1
- If mode=1: rr_ptr <= g.
- If mode=0: rr_ptr is unchanged.

Transfer out (out_valid && out_ready at a clk edge):
- If no new transfer in happens on the same edge, out_valid <= 0. out_data and out_chan hold their last values.
- Simultaneous transfer out and transfer in: the new word replaces the old one, out_valid stays 1, and no bubble is inserted.

Latency and throughput:
- Latency is 1 cycle: data accepted at edge k appears on out_data after edge k.

Stall:
- While out_valid=1 and out_ready=0: out_data, out_chan and out_valid hold stable, and in_ready is all zeros.

Disable:
- enable=0 blocks new grants.
- A word already held in the output register still drains normally through out_ready.
- rr_ptr is frozen while enable=0.

Mode change:
- Mode may change on any cycle and takes effect for the grant in that same cycle.
- rr_ptr keeps its value across mode changes.

Wrap-around:
- The round-robin pointer wraps from N-1 to 0.
- A single continuously valid channel is granted every cycle.
- All channels continuously valid are granted in the order 0,1,…,N-1,0,…

Test Plan (N=4, WIDTH=16; in_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}):

1. Reset check: assert rst for 2 cycles with all in_valid=1.
   -> out_valid=0, out_data=0, out_chan=0, in_ready=4'b0000 throughout.
2. Fixed select: mode=0, sel=2, in_valid=4'b1111, out_ready=1, enable=1.
   -> in_ready=4'b0100; next cycle out_data=16'hCCCC, out_chan=2, out_valid=1; repeats every cycle.
   -> With sel=2 and in_valid=4'b1011: no grant, and out_valid drops to 0 after one cycle.
3. Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles after reset.
   -> out_chan sequence 0,1,2,3,0,1,2,3; out_data AAAA,BBBB,CCCC,DDDD,…
   -> With in_valid=4'b1010: sequence 1,3,1,3.
4. Backpressure: mode=1, all valid, out_ready=0 for 3 cycles after the first word.
   -> out_data=16'hAAAA, out_chan=0 held stable; in_ready=4'b0000.
   -> Releasing out_ready: the next word is 16'hBBBB with no duplicate or skipped word.
5. Enable and drain: load a word, then enable=0 with out_ready=1.
   -> The word drains and out_valid=0 next cycle; in_ready stays 0000.
   -> Re-enabling in mode=1 resumes from the channel after the last granted one.
6. Reset mid-stream: assert rst while out_valid=1, out_ready=0.
   -> out_valid=0, out_data=0 after the edge.
   -> The first round-robin grant after reset goes to channel 0.

Source files
------------

// File: rtl/mux_nx1_reg.sv
// N-input registered multiplexer with valid/ready handshakes on every channel.
// Channels are picked by a fixed select or by a round-robin pointer that rotates among valid channels.
module mux_nx1_reg #(
  parameter  int WIDTH = 16,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_chan
);

  logic             load;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             take;
  logic [SELW-1:0]  rr_ptr;

  assign load = enable && (!out_valid || out_ready);
  assign take = load && grant_vld && !rst;

  // Round-robin starts scanning one past the last granted channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        for (int i = 0; i < N; i++) begin
          if (!grant_vld && i == (int'(rr_ptr) + k) % N && in_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = SELW'(i);
          end
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = take;
      end
    end
  end

  // A new word may replace the outgoing one on the same edge, keeping throughput at one per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      rr_ptr    <= SELW'(N - 1);
    end else if (take) begin
      out_data  <= grant_data;
      out_chan  <= grant_idx;
      out_valid <= 1'b1;
      if (mode) begin
        rr_ptr <= grant_idx;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
